// File: rtl/nr_divider_seq_if.sv
// Operand/result handshake bundle for nr_divider_seq.
// The master side supplies operands and consumes results; the slave side is the divider.
interface nr_divider_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/nr_divider_seq.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero and raise div_zero.
module nr_divider_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  nr_divider_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dz_pend;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step_rem;

  // Partial remainder is WIDTH+1 bits two's complement; wraparound in the
  // shifted intermediate is harmless since each step result lies in [-D, D).
  always_comb begin
    dvs_ext  = {1'b0, dvs};
    shifted  = {part_rem[WIDTH-1:0], quo[WIDTH-1]};
    step_rem = part_rem[WIDTH] ? shifted + dvs_ext : shifted - dvs_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      part_rem    <= '0;
      quo         <= '0;
      dvs         <= '0;
      dz_pend     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= RUN;
            in_ready_q <= 1'b0;
            count      <= '0;
            part_rem   <= '0;
            quo        <= bus.dividend;
            dvs        <= bus.divisor;
            dz_pend    <= DZ_EN && (bus.divisor == '0);
          end
        end
        RUN: begin
          if (dz_pend) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= quo;
            div_zero_q  <= 1'b1;
          end else begin
            part_rem <= step_rem;
            quo      <= {quo[WIDTH-2:0], ~step_rem[WIDTH]};
            if (count == CW'(WIDTH - 1)) begin
              state <= FIX;
              count <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        FIX: begin
          // First cycle corrects a negative remainder, second publishes results.
          if (count == '0) begin
            if (part_rem[WIDTH]) part_rem <= part_rem + dvs_ext;
            count <= CW'(1);
          end else begin
            state       <= DONE;
            count       <= '0;
            out_valid_q <= 1'b1;
            quotient_q  <= quo;
            remainder_q <= part_rem[WIDTH-1:0];
            div_zero_q  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/nr_divider_seq.md
NR_DIVIDER_SEQ -- requirements
Module: nr_divider_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width (legal range 2..32).
REQ-002 The module SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid  input  1  dividend/divisor present.
REQ-005 The module SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The module SHALL have port dividend  input  WIDTH  unsigned dividend.
REQ-007 The module SHALL have port divisor  input  WIDTH  unsigned divisor.
REQ-008 The module SHALL have port out_valid  output  1  results valid.
REQ-009 The module SHALL have port out_ready  input  1  consumer accepts results.
REQ-010 The module SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-011 The module SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-012 The module SHALL have port div_zero  output  1  divide-by-zero flag; tied 0 when DIV_ZERO_DETECT_EN is undefined.

Function
REQ-013 The block SHALL perform unsigned non-restoring division, one quotient bit per clock, using a WIDTH+1-bit signed partial remainder.
REQ-014 The FSM SHALL have states IDLE, RUN, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur on a clk edge with in_valid & in_ready; operands are latched and the state goes IDLE->RUN, step counter = 0, partial remainder = 0.
REQ-016 Each RUN cycle: shift {R,Q} left one bit; if R was >= 0 then R = R - divisor, else R = R + divisor; new Q LSB = 1 if resulting R >= 0, else 0.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL add divisor to R when R < 0 (remainder correction), then go to DONE.
REQ-019 Latency: with acceptance at edge T, out_valid SHALL rise after edge T+WIDTH+2.
REQ-020 In DONE, out_valid = 1 and quotient/remainder/div_zero SHALL hold stable until out_valid & out_ready; then go to IDLE (in_ready = 1 the next cycle).
REQ-021 out_ready held 0 SHALL stall indefinitely in DONE without corrupting results.
REQ-022 in_valid while not in IDLE SHALL be ignored; operand inputs SHALL not affect a division in progress.
REQ-023 quotient/remainder SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for every divisor != 0.

Reset
REQ-024 reset SHALL take priority over all other events in any state, including mid-RUN and DONE, and the operation SHALL be discarded.
REQ-025 After reset: state IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, counter = 0.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN SHALL control divide-by-zero detection.
REQ-027 With DIV_ZERO_DETECT_EN defined: divisor == 0 at acceptance SHALL skip RUN/FIX, enter DONE on the next edge with div_zero = 1, quotient = all ones, remainder = dividend.
REQ-028 Without DIV_ZERO_DETECT_EN: divisor == 0 SHALL run the normal WIDTH+2-cycle sequence, yielding quotient = all ones, remainder = dividend; div_zero SHALL stay 0.

Verification
REQ-029 WIDTH=8, 100/7, out_ready=1 -> quotient 14, remainder 2, out_valid rises 10 edges after acceptance.
REQ-030 WIDTH=8, 5/9 and 255/1 -> (0,5) and (255,0); 255/255 -> (1,0).
REQ-031 WIDTH=8, 200/0 -> with macro: out_valid after 1 edge, div_zero=1, (255,200); without macro: after 10 edges, div_zero=0, (255,200).
REQ-032 Assert reset during RUN cycle 4 of 100/7 -> next cycle in_ready=1, out_valid=0, outputs 0; new 50/6 then yields (8,2).
REQ-033 Hold out_ready=0 for 20 cycles in DONE with in_valid=1 and changing operands -> results stay (14,2), in_ready=0; out_ready=1 completes the handshake and in_ready=1 the following cycle.
REQ-034 Random back-to-back operands (WIDTH=8 and WIDTH=16, >=10k vectors) -> every result matches a reference model per REQ-023.
